// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-LED running-light generator with rotate, bounce and bar-fill patterns,
// stepped by a clock divider whose period is TICK_DIV >> speed.
module led_pattern_gen #(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0]    cnt, lim;
  logic [1:0]       mode_q;
  logic             dir, nxt_dir;
  logic [N_LED-1:0] nxt_led;
  assign lim = CW'((TICK_DIV >> speed) - 1);
  // Bounce flips direction on the same step that lands on an end LED.
  always_comb begin
    nxt_led = mode_q == 2'd0 ? {led[N_LED-2:0], led[N_LED-1]} :
              mode_q == 2'd1 ? {led[0], led[N_LED-1:1]} :
              mode_q == 2'd2 ? (dir ? led >> 1 : led << 1) :
              &led ? '0 : {led[N_LED-2:0], 1'b1};
    nxt_dir = mode_q == 2'd2 ? (dir ? !led[1] : led[N_LED-2]) : dir;
  end
  always_ff @(posedge clk) begin
    if (rst || mode != mode_q) begin
      led    <= N_LED'(1);
      cnt    <= '0;
      dir    <= 1'b0;
      mode_q <= mode;
      step   <= 1'b0;
    end else if (en && cnt >= lim) begin
      cnt  <= '0;
      led  <= nxt_led;
      dir  <= nxt_dir;
      step <= 1'b1;
    end else begin
      cnt  <= en ? cnt + 1'b1 : cnt;
      step <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen with N_LED=4, TICK_DIV=8.
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst, en, step;
  logic [1:0] mode, speed;
  logic [3:0] led, cur;
  int         total = 0, pass = 0;

  led_pattern_gen #(.N_LED(4), .TICK_DIV(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .led(led), .step(step)
  );

  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // n clocks from now the LEDs must step to exp; before that they hold with step low.
  task automatic adv(input int n, input logic [3:0] exp, input string tag);
    if (n > 1) begin
      repeat (n - 1) @(negedge clk);
      chk({tag, " hold step"}, 32'(step), 0);
      chk({tag, " hold led"}, 32'(led), 32'(cur));
    end
    @(negedge clk);
    chk({tag, " step"}, 32'(step), 1);
    chk({tag, " led"}, 32'(led), 32'(exp));
    cur = exp;
  endtask

  task automatic set_mode(input logic [1:0] m, input string tag);
    mode = m;
    @(negedge clk);
    chk({tag, " reload led"}, 32'(led), 1);
    chk({tag, " reload step"}, 32'(step), 0);
    cur = 4'b0001;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; speed = 2'd0; cur = 4'b0001;
    repeat (2) @(negedge clk);
    chk("reset led", 32'(led), 1);
    chk("reset step", 32'(step), 0);
    rst = 1'b0;
    adv(8, 4'b0010, "rotl1");
    adv(8, 4'b0100, "rotl2");
    adv(8, 4'b1000, "rotl3");
    adv(8, 4'b0001, "rotl4");

    speed = 2'd1;
    set_mode(2'd1, "to_rotr");
    adv(4, 4'b1000, "rotr1");
    adv(4, 4'b0100, "rotr2");
    adv(4, 4'b0010, "rotr3");

    set_mode(2'd2, "to_bounce");
    adv(4, 4'b0010, "bnc1");
    adv(4, 4'b0100, "bnc2");
    adv(4, 4'b1000, "bnc3");
    adv(4, 4'b0100, "bnc4");
    adv(4, 4'b0010, "bnc5");
    adv(4, 4'b0001, "bnc6");
    adv(4, 4'b0010, "bnc7");

    speed = 2'd3;
    set_mode(2'd3, "to_bar");
    adv(1, 4'b0011, "bar1");
    adv(1, 4'b0111, "bar2");
    adv(1, 4'b1111, "bar3");
    adv(1, 4'b0000, "bar4");
    adv(1, 4'b0001, "bar5");

    speed = 2'd0;
    set_mode(2'd0, "pause_rotl");
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pause step", 32'(step), 0);
    end
    chk("pause led", 32'(led), 1);
    en = 1'b1;
    adv(5, 4'b0010, "resume");

    adv(8, 4'b0100, "pre_mchg");
    repeat (5) @(negedge clk);
    set_mode(2'd2, "mchg");
    adv(8, 4'b0010, "mchg_bnc");

    set_mode(2'd3, "rst_bar");
    adv(8, 4'b0011, "rbar1");
    adv(8, 4'b0111, "rbar2");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst led", 32'(led), 1);
    chk("midrst step", 32'(step), 0);
    rst = 1'b0;
    cur = 4'b0001;
    repeat (6) @(negedge clk);
    speed = 2'd2;
    adv(1, 4'b0011, "spd_jump");
    adv(2, 4'b0111, "spd_fast");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised running-light generator, successor to the fixed 8-LED `led_run` block. It drives an N-bit LED bank with four selectable patterns: rotate left, rotate right, bounce and bar-fill. Step rate is set by a clock divider plus a run-time speed select, and a pause input freezes the pattern. It sits directly between the board clock/reset and the LED pins and can run unattended from power-up.

## Interface

- `N_LED`, default 8: number of LEDs. Legal values are 2 and up.
- `TICK_DIV`, default 25_000_000: clocks per step at speed 0, which gives 0.5 s at 50 MHz. Legal values are 8 and up.
- `clk` in 1: system clock, 50 MHz on the board.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `en` in 1: 1 runs the pattern, 0 pauses it (divider and LEDs hold).
- `mode` in 2: 0 ROTL, 1 ROTR, 2 BOUNCE, 3 BAR.
- `speed` in 2: step period is `TICK_DIV >> speed` clocks.
- `led` out N_LED: LED drive, active-high.
- `step` out 1: one-cycle pulse, high in the same cycle as each `led` update.

## Operation

- Internal state:
  - divider counter `cnt`, width $clog2(TICK_DIV).
  - registered mode `mode_q`.
  - bounce direction `dir` (0 = toward MSB).
- Reset values, with `rst`=1 sampled at a rising edge:
  - `led` = 1 (bit 0 lit).
  - `cnt` = 0, `dir` = 0, `mode_q` = `mode` input.
  - `step` = 0.
- Limit is `lim = (TICK_DIV >> speed) - 1`, evaluated combinationally every cycle.
- Each enabled cycle:
  - If `cnt >= lim`: `cnt` <= 0, `led` advances one pattern step, `step` <= 1.
  - Otherwise: `cnt` <= `cnt`+1, `step` <= 0.
  - The `>=` compare means a speed increase while `cnt` is above the new limit steps on the next cycle, not after a counter wrap.
- `en`=0: `cnt`, `led` and `dir` hold; `step` <= 0.
- Pattern steps:
  - ROTL: rotate left by 1; bit N-1 wraps to bit 0.
  - ROTR: rotate right by 1; bit 0 wraps to bit N-1.
  - BOUNCE: one lit LED.
    - `dir`=0 shifts left; on reaching bit N-1, `dir` <= 1.
    - `dir`=1 shifts right; on reaching bit 0, `dir` <= 0.
    - The direction flips in the same step that reaches the end, so endpoints are lit for exactly one step. The period is 2N-2 steps.
  - BAR: thermometer fill, `led` <= {led[N-2:0],1'b1}.
    - From all-ones, the next step is all-zeros.
    - From all-zeros, the next step is 1.
    - The period is N+1 steps.
- Mode change: when `mode` != `mode_q` (checked regardless of `en`), on the next edge:
  - `mode_q` <= `mode`, `led` <= 1, `cnt` <= 0, `dir` <= 0, `step` <= 0.
  - The pattern step is suppressed that cycle.
- Entering BOUNCE with an illegal state cannot occur, because every mode change reloads `led`=1.
- Priority: `rst` > mode change > `en`/step logic.
- Speed change never reloads `led`; it only moves the limit.

## Timing

- All outputs are registered. There are no combinational paths from inputs to outputs.
- First `led` update after reset: the edge at which `cnt` reaches `lim`, i.e. `lim`+1 enabled clocks after the first edge with `rst`=0.
- Steady state: `led` changes and `step` pulses every `lim`+1 enabled clocks.
- `step` is exactly one cycle wide, aligned with the new `led` value.
- Mode change latency is 1 clock (`led`=1 visible after the next edge). The first step in the new mode comes `lim`+1 enabled clocks later.
- Pause/resume: deasserting `en` freezes `cnt` mid-count. Resuming continues from the frozen count, so total enabled clocks per step are unchanged.
- `rst` mid-pattern: `led` reads 1 and `cnt` reads 0 after that edge, whatever the mode or `en`.

## Test plan

Bench parameters for all scenarios: `N_LED`=4, `TICK_DIV`=8, 20 ns clock.

1. **ROTL, speed 0, en=1, reset release.** `led` = 0001, 0010, 0100, 1000, 0001 with a step every 8 clocks. The first step comes 8 clocks after `rst` falls. `step` pulses are one cycle wide.
2. **ROTR and BOUNCE, speed 1 (period 4).**
   - ROTR gives 0001, 1000, 0100, 0010.
   - BOUNCE gives 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, so the period is 6 with no repeated endpoints.
3. **BAR, speed 3 (period 1).** `led` = 0001, 0011, 0111, 1111, 0000, 0001 on consecutive cycles, with `step` held high continuously.
4. **Pause.** In ROTL, drop `en` for 20 clocks when `cnt`=3. Required response:
   - `led` and `step` are frozen and `step` stays 0.
   - After `en` returns, the next step comes 5 clocks later.
5. **Mode change.** Switch ROTL to BOUNCE while `led`=0100 and `cnt`=5. `led`=0001 appears 1 clock later, and the next step (to 0010) comes 8 clocks after that.
6. **Reset mid-run, and speed change.**
   - Assert `rst` for one clock in BAR while `led`=0111: `led`=0001 and `step`=0 on the next edge.
   - Separately, change `speed` 0→2 while `cnt`=6: a step occurs on the next clock.
